// File: rtl/tile_pixel_fetch.sv
// Pixel-rate tile fetch: tilemap address -> VRAM/CRAM code+palette -> tile ROM row
// -> 8-bit colour-lookup index. Fixed 5-cycle latency, one pixel per cycle, no stall.
// VRAM/CRAM reads are skipped while consecutive accepted pixels stay in the same tile.
module tile_pixel_fetch #(
   parameter int unsigned ACTIVE_ROWS = 288,
   parameter int unsigned ACTIVE_COLS = 224
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic        pix_valid,
   input  logic [8:0]  row,
   input  logic [9:0]  col,
   input  logic [15:0] tile_raw_addr,
   output logic [9:0]  vram_addr,
   output logic        vram_re,
   input  logic [7:0]  vram_data,
   input  logic [7:0]  cram_data,
   output logic [10:0] rom_addr,
   input  logic [15:0] rom_data,
   output logic [7:0]  color_idx,
   output logic        color_valid
);

   // Upper address bits and top palette bits are not part of the datapath.
   logic unused_bits;
   assign unused_bits = ^{tile_raw_addr[15:10], cram_data[7:6]};

   // S1: address issue and same-tile read suppression
   logic        accept;
   logic        rd_d;
   logic        s1_vld_q;
   logic [2:0]  s1_frow_q, s1_fcol_q;
   logic [9:0]  vram_addr_q;
   logic        vram_re_q;
   logic [9:0]  last_addr_q;
   logic        last_vld_q;

   // D1: aligns the pixel with RAM data returning a cycle after the strobe
   logic        d1_vld_q, d1_rd_q;
   logic [2:0]  d1_frow_q, d1_fcol_q;

   // S2: code/palette select and ROM address
   logic [7:0]  code_eff;
   logic [5:0]  pal_eff;
   logic [7:0]  code_hold_q;
   logic [5:0]  pal_hold_q;
   logic        s2_vld_q;
   logic [5:0]  s2_pal_q;
   logic [2:0]  s2_fcol_q;
   logic [10:0] rom_addr_q;

   // D2: aligns the pixel with ROM data returning a cycle after the address
   logic        d2_vld_q;
   logic [5:0]  d2_pal_q;
   logic [2:0]  d2_fcol_q;

   // S3: output
   logic [15:0] pix_sh;
   logic [7:0]  color_idx_q;
   logic        color_valid_q;

   // Acceptance and read-request decision for the incoming pixel
   always_comb begin
      accept = pix_valid && ({23'd0, row} < ACTIVE_ROWS) && ({22'd0, col} < ACTIVE_COLS);
      rd_d   = accept && (!last_vld_q || (tile_raw_addr[9:0] != last_addr_q));
   end

   // S1 register; any bubble drops the last-tile memory so the next pixel re-reads
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         s1_vld_q    <= 1'b0;
         s1_frow_q   <= '0;
         s1_fcol_q   <= '0;
         vram_addr_q <= '0;
         vram_re_q   <= 1'b0;
         last_addr_q <= '0;
         last_vld_q  <= 1'b0;
      end else begin
         s1_vld_q    <= accept;
         s1_frow_q   <= row[2:0];
         s1_fcol_q   <= col[2:0];
         vram_addr_q <= tile_raw_addr[9:0];
         vram_re_q   <= rd_d;
         if (accept) begin
            last_addr_q <= tile_raw_addr[9:0];
            last_vld_q  <= 1'b1;
         end else begin
            last_vld_q  <= 1'b0;
         end
      end
   end

   // D1 delay register carrying the read flag to where RAM data is valid
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         d1_vld_q  <= 1'b0;
         d1_rd_q   <= 1'b0;
         d1_frow_q <= '0;
         d1_fcol_q <= '0;
      end else begin
         d1_vld_q  <= s1_vld_q;
         d1_rd_q   <= vram_re_q;
         d1_frow_q <= s1_frow_q;
         d1_fcol_q <= s1_fcol_q;
      end
   end

   // Fresh RAM data when this pixel read, otherwise the held copy of its tile
   always_comb begin
      code_eff = d1_rd_q ? vram_data : code_hold_q;
      pal_eff  = d1_rd_q ? cram_data[5:0] : pal_hold_q;
   end

   // S2 register: ROM address issue and hold refresh
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         code_hold_q <= '0;
         pal_hold_q  <= '0;
         s2_vld_q    <= 1'b0;
         s2_pal_q    <= '0;
         s2_fcol_q   <= '0;
         rom_addr_q  <= '0;
      end else begin
         if (d1_rd_q) begin
            code_hold_q <= vram_data;
            pal_hold_q  <= cram_data[5:0];
         end
         s2_vld_q   <= d1_vld_q;
         s2_pal_q   <= pal_eff;
         s2_fcol_q  <= d1_fcol_q;
         rom_addr_q <= {code_eff, d1_frow_q};
      end
   end

   // D2 delay register carrying palette/fine_col to where ROM data is valid
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         d2_vld_q  <= 1'b0;
         d2_pal_q  <= '0;
         d2_fcol_q <= '0;
      end else begin
         d2_vld_q  <= s2_vld_q;
         d2_pal_q  <= s2_pal_q;
         d2_fcol_q <= s2_fcol_q;
      end
   end

   // Leftmost pixel lives in the top two bits; shift the selected pair up to [15:14]
   always_comb begin
      pix_sh = rom_data << {d2_fcol_q, 1'b0};
   end

   // S3 output register; bubbles produce a zero index
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         color_idx_q   <= '0;
         color_valid_q <= 1'b0;
      end else if (d2_vld_q) begin
         color_idx_q   <= {d2_pal_q, pix_sh[15:14]};
         color_valid_q <= 1'b1;
      end else begin
         color_idx_q   <= '0;
         color_valid_q <= 1'b0;
      end
   end

   assign vram_addr   = vram_addr_q;
   assign vram_re     = vram_re_q;
   assign rom_addr    = rom_addr_q;
   assign color_idx   = color_idx_q;
   assign color_valid = color_valid_q;

endmodule
